// File: rtl/alu_sequencer.sv
// Three-phase (IDLE/EXEC/WB) instruction sequencer in front of an external combinational ALU.
// Owns a 4x8 register file and the C/Z flags, and commits the ALU result at the end of WB.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ins_valid,
    output logic       ins_ready,
    input  logic [2:0] ins_op,
    input  logic [1:0] ins_rd,
    input  logic [1:0] ins_rs,
    input  logic [7:0] ins_imm,
    output logic       alu_m,
    output logic [3:0] alu_s,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_t,
    input  logic       alu_cf,
    input  logic       alu_zf,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       flag_c,
    output logic       flag_z,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_t;

    typedef enum logic [2:0] {
        OP_MOV,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_NOT,
        OP_LDI,
        OP_OUT,
        OP_NOP
    } op_t;

    state_t      state_q;
    op_t         op_q;
    logic [1:0]  rd_q;
    logic [7:0]  regs_q [4];
    logic        flag_c_q;
    logic        flag_z_q;
    logic        out_valid_q;
    logic [7:0]  out_data_q;
    logic        alu_m_q;
    logic [3:0]  alu_s_q;
    logic [7:0]  alu_a_q;
    logic [7:0]  alu_b_q;

    logic        alu_m_d;
    logic [3:0]  alu_s_d;
    logic [7:0]  alu_a_d;
    logic [7:0]  alu_b_d;

    // ALU controls/operands for the offered instruction, captured on the accepting edge.
    always_comb begin
        alu_m_d = 1'b0;
        alu_s_d = 4'b0000;
        alu_a_d = regs_q[ins_rs];
        alu_b_d = regs_q[ins_rd];
        case (op_t'(ins_op))
            OP_MOV: begin
                alu_s_d = 4'b1010;
                alu_b_d = regs_q[ins_rs];
            end
            OP_ADD: begin
                alu_m_d = 1'b1;
                alu_s_d = 4'b1001;
            end
            OP_SUB: begin
                alu_m_d = 1'b1;
                alu_s_d = 4'b0110;
            end
            OP_AND: begin
                alu_m_d = 1'b1;
                alu_s_d = 4'b1011;
            end
            OP_NOT: begin
                alu_m_d = 1'b1;
                alu_s_d = 4'b0101;
                alu_b_d = regs_q[ins_rs];
            end
            OP_LDI: begin
                alu_s_d = 4'b1100;
                alu_a_d = ins_imm;
            end
            OP_OUT: begin
                alu_s_d = 4'b1100;
                alu_a_d = regs_q[ins_rd];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_NOP;
            rd_q        <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            alu_m_q     <= 1'b0;
            alu_s_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ins_valid) begin
                        state_q <= EXEC;
                        op_q    <= op_t'(ins_op);
                        rd_q    <= ins_rd;
                        alu_m_q <= alu_m_d;
                        alu_s_q <= alu_s_d;
                        alu_a_q <= alu_a_d;
                        alu_b_q <= alu_b_d;
                    end
                end
                EXEC: begin
                    state_q <= WB;
                    // ALU operands are already stable, so the OUT value can be captured a cycle early.
                    if (op_q == OP_OUT) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= alu_t;
                    end
                end
                WB: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    alu_m_q     <= 1'b0;
                    alu_s_q     <= '0;
                    alu_a_q     <= '0;
                    alu_b_q     <= '0;
                    if (op_q != OP_OUT && op_q != OP_NOP) begin
                        regs_q[rd_q] <= alu_t;
                    end
                    if (op_q == OP_ADD || op_q == OP_SUB) begin
                        flag_c_q <= alu_cf;
                        flag_z_q <= alu_zf;
                    end else if (op_q == OP_AND || op_q == OP_NOT) begin
                        flag_c_q <= 1'b0;
                        flag_z_q <= (alu_t == '0);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ins_ready = (state_q == IDLE);
    assign alu_m     = alu_m_q;
    assign alu_s     = alu_s_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;
    assign dbg_data  = regs_q[dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, instruction-level reference model checked every
// cycle, plus directed programs with hand-computed register and flag values.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ins_valid = 1'b0;
    logic       ins_ready;
    logic [2:0] ins_op = '0;
    logic [1:0] ins_rd = '0;
    logic [1:0] ins_rs = '0;
    logic [7:0] ins_imm = '0;
    logic       alu_m;
    logic [3:0] alu_s;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_t;
    logic       alu_cf;
    logic       alu_zf;
    logic       out_valid;
    logic [7:0] out_data;
    logic       flag_c;
    logic       flag_z;
    logic [1:0] dbg_sel = '0;
    logic [7:0] dbg_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins_op    (ins_op),
        .ins_rd    (ins_rd),
        .ins_rs    (ins_rs),
        .ins_imm   (ins_imm),
        .alu_m     (alu_m),
        .alu_s     (alu_s),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_t     (alu_t),
        .alu_cf    (alu_cf),
        .alu_zf    (alu_zf),
        .out_valid (out_valid),
        .out_data  (out_data),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    // External ALU: function selected by {m,s}, zero flag from the result.
    always_comb begin
        alu_t  = '0;
        alu_cf = 1'b0;
        case ({alu_m, alu_s})
            5'b0_1010: alu_t = alu_b;
            5'b1_1001: {alu_cf, alu_t} = {1'b0, alu_b} + {1'b0, alu_a};
            5'b1_0110: begin
                alu_t  = alu_b - alu_a;
                alu_cf = (alu_b < alu_a);
            end
            5'b1_1011: alu_t = alu_a & alu_b;
            5'b1_0101: alu_t = ~alu_b;
            5'b0_1100: alu_t = alu_a;
            default: ;
        endcase
        alu_zf = (alu_t == 8'h00);
    end

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: instruction semantics evaluated at acceptance, committed two edges later.
    int         phase = 0;
    logic [2:0] m_op = '0;
    logic [1:0] m_rd = '0;
    logic [7:0] mR [4] = '{default: 8'h00};
    logic [7:0] m_res = '0;
    logic [7:0] m_a = '0;
    logic [7:0] m_b = '0;
    logic       m_wr = 1'b0;
    logic       m_fl = 1'b0;
    logic       m_rc = 1'b0;
    logic       m_rz = 1'b0;
    logic       m_c = 1'b0;
    logic       m_z = 1'b0;
    logic       m_ov = 1'b0;
    logic [7:0] m_od = '0;

    function automatic logic [4:0] exp_ms(input logic [2:0] op);
        case (op)
            3'd0:    return 5'b0_1010;
            3'd1:    return 5'b1_1001;
            3'd2:    return 5'b1_0110;
            3'd3:    return 5'b1_1011;
            3'd4:    return 5'b1_0101;
            3'd5:    return 5'b0_1100;
            3'd6:    return 5'b0_1100;
            default: return 5'b0_0000;
        endcase
    endfunction

    task automatic model_accept();
        logic [7:0] src;
        logic [7:0] dst;
        src   = mR[ins_rs];
        dst   = mR[ins_rd];
        m_op  = ins_op;
        m_rd  = ins_rd;
        m_a   = src;
        m_b   = dst;
        m_wr  = 1'b1;
        m_fl  = 1'b0;
        m_rc  = 1'b0;
        m_res = 8'h00;
        case (ins_op)
            3'd0: begin m_res = src; m_b = src; end
            3'd1: begin {m_rc, m_res} = {1'b0, dst} + {1'b0, src}; m_fl = 1'b1; end
            3'd2: begin m_res = dst - src; m_rc = (dst < src); m_fl = 1'b1; end
            3'd3: begin m_res = src & dst; m_fl = 1'b1; end
            3'd4: begin m_res = ~src; m_b = src; m_fl = 1'b1; end
            3'd5: begin m_res = ins_imm; m_a = ins_imm; end
            3'd6: begin m_res = dst; m_a = dst; m_wr = 1'b0; end
            default: m_wr = 1'b0;
        endcase
        m_rz = (m_res == 8'h00);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase = 0;
            for (int i = 0; i < 4; i++) mR[i] = 8'h00;
            m_c  = 1'b0;
            m_z  = 1'b0;
            m_ov = 1'b0;
            m_od = 8'h00;
        end else begin
            m_ov = 1'b0;
            if (phase == 2) begin
                if (m_wr) mR[m_rd] = m_res;
                if (m_fl) begin
                    m_c = m_rc;
                    m_z = m_rz;
                end
                phase = 0;
            end else if (phase == 1) begin
                phase = 2;
                if (m_op == 3'd6) begin
                    m_ov = 1'b1;
                    m_od = m_res;
                end
            end else if (ins_valid) begin
                model_accept();
                phase = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0] ms;
        ms = (phase == 0) ? 5'b0_0000 : exp_ms(m_op);
        chk1("ins_ready", ins_ready, phase == 0);
        chk1("out_valid", out_valid, m_ov);
        chk8("out_data", out_data, m_od);
        chk1("flag_c", flag_c, m_c);
        chk1("flag_z", flag_z, m_z);
        chk8("dbg_data", dbg_data, mR[dbg_sel]);
        chk1("alu_m", alu_m, ms[4]);
        chk8("alu_s", {4'h0, alu_s}, {4'h0, ms[3:0]});
        chk8("alu_a", alu_a, (phase == 0) ? 8'h00 : m_a);
        chk8("alu_b", alu_b, (phase == 0) ? 8'h00 : m_b);
    end

    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [7:0] imm);
        int   n;
        logic r;
        ins_op    = op;
        ins_rd    = rd;
        ins_rs    = rs;
        ins_imm   = imm;
        ins_valid = 1'b1;
        dbg_sel   = rd;
        n = 0;
        r = 1'b0;
        while (!r && n < 20) begin
            @(negedge clk);
            r = ins_ready;
            @(posedge clk);
            n++;
        end
        #2 ins_valid = 1'b0;
        checks++;
        if (!r) begin
            errors++;
            $display("FAIL issue_timeout: ins_ready=0 expected 1 within 20 cycles at %0t", $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_reg(input string name, input logic [1:0] sel, input logic [7:0] exp);
        dbg_sel = sel;
        #1;
        chk8(name, dbg_data, exp);
    endtask

    initial begin
        int         cnt;
        logic [7:0] d;

        repeat (2) @(posedge clk);
        #2;
        chk1("reset flag_c", flag_c, 1'b0);
        chk1("reset flag_z", flag_z, 1'b0);
        chk1("reset ins_ready", ins_ready, 1'b1);
        chk1("reset out_valid", out_valid, 1'b0);
        chk8("reset out_data", out_data, 8'h00);
        rst_n = 1'b1;
        idle(1);

        // LDI r0,5; LDI r1,3; ADD r0,r1
        issue(3'd5, 2'd0, 2'd0, 8'h05);
        issue(3'd5, 2'd1, 2'd0, 8'h03);
        issue(3'd1, 2'd0, 2'd1, 8'h00);
        idle(3);
        chk_reg("ADD R0", 2'd0, 8'h08);
        chk8("model ADD R0", mR[0], 8'h08);
        chk1("ADD flag_c", flag_c, 1'b0);
        chk1("ADD flag_z", flag_z, 1'b0);

        // LDI r2,FF; LDI r3,01; ADD r2,r3 -> wrap
        issue(3'd5, 2'd2, 2'd0, 8'hFF);
        issue(3'd5, 2'd3, 2'd0, 8'h01);
        issue(3'd1, 2'd2, 2'd3, 8'h00);
        idle(3);
        chk_reg("ADD wrap R2", 2'd2, 8'h00);
        chk1("ADD wrap flag_c", flag_c, 1'b1);
        chk1("ADD wrap flag_z", flag_z, 1'b1);
        chk1("model ADD wrap c", m_c, 1'b1);

        // LDI r0,3; LDI r1,5; SUB r0,r1; NOT r2,r0
        issue(3'd5, 2'd0, 2'd0, 8'h03);
        issue(3'd5, 2'd1, 2'd0, 8'h05);
        issue(3'd2, 2'd0, 2'd1, 8'h00);
        idle(3);
        chk_reg("SUB R0", 2'd0, 8'hFE);
        chk1("SUB flag_c", flag_c, 1'b1);
        chk1("SUB flag_z", flag_z, 1'b0);
        issue(3'd4, 2'd2, 2'd0, 8'h00);
        idle(3);
        chk_reg("NOT R2", 2'd2, 8'h01);
        chk8("model NOT R2", mR[2], 8'h01);
        chk1("NOT flag_c", flag_c, 1'b0);
        chk1("NOT flag_z", flag_z, 1'b0);

        // LDI r1,A5; OUT r1
        issue(3'd5, 2'd1, 2'd0, 8'hA5);
        issue(3'd6, 2'd1, 2'd0, 8'h00);
        cnt = 0;
        d   = 8'h00;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                d = out_data;
            end
        end
        @(posedge clk);
        #2;
        chk8("OUT pulse count", cnt[7:0], 8'd1);
        chk8("OUT data", d, 8'hA5);
        chk_reg("OUT R1 unchanged", 2'd1, 8'hA5);
        chk1("OUT flag_c unchanged", flag_c, 1'b0);
        chk1("OUT flag_z unchanged", flag_z, 1'b0);

        // ins_valid held high with a changing LDI each cycle
        cnt = 0;
        ins_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            ins_op  = 3'd5;
            ins_rd  = 2'(i % 4);
            ins_imm = 8'(16 + i);
            @(negedge clk);
            if (ins_ready) cnt++;
            @(posedge clk);
            #2;
        end
        ins_valid = 1'b0;
        idle(3);
        chk8("b2b accept count", cnt[7:0], 8'd3);
        chk_reg("b2b R0", 2'd0, 8'h10);
        chk_reg("b2b R3", 2'd3, 8'h13);
        chk_reg("b2b R2", 2'd2, 8'h16);
        chk_reg("b2b R1", 2'd1, 8'hA5);

        // SUB r1,r1 with rd==rs
        issue(3'd5, 2'd1, 2'd0, 8'h42);
        issue(3'd2, 2'd1, 2'd1, 8'h00);
        idle(3);
        chk_reg("SUB self R1", 2'd1, 8'h00);
        chk1("SUB self flag_z", flag_z, 1'b1);
        chk1("SUB self flag_c", flag_c, 1'b0);

        // AND r3,r2; MOV r0,r3; NOP
        issue(3'd5, 2'd2, 2'd0, 8'hF0);
        issue(3'd5, 2'd3, 2'd0, 8'h3C);
        issue(3'd3, 2'd3, 2'd2, 8'h00);
        issue(3'd0, 2'd0, 2'd3, 8'h00);
        issue(3'd7, 2'd0, 2'd1, 8'h99);
        idle(3);
        chk_reg("AND R3", 2'd3, 8'h30);
        chk_reg("MOV R0", 2'd0, 8'h30);
        chk1("AND flag_z", flag_z, 1'b0);

        // Reset during EXEC of ADD r0,r1 with R0=8
        issue(3'd5, 2'd0, 2'd0, 8'h05);
        issue(3'd5, 2'd1, 2'd0, 8'h03);
        issue(3'd1, 2'd0, 2'd1, 8'h00);
        idle(3);
        chk_reg("pre-abort R0", 2'd0, 8'h08);
        issue(3'd1, 2'd0, 2'd1, 8'h00);
        rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(3);
        chk_reg("abort R0", 2'd0, 8'h00);
        chk_reg("abort R1", 2'd1, 8'h00);
        chk_reg("abort R2", 2'd2, 8'h00);
        chk_reg("abort R3", 2'd3, 8'h00);
        chk1("abort flag_c", flag_c, 1'b0);
        chk1("abort flag_z", flag_z, 1'b0);
        chk1("abort ins_ready", ins_ready, 1'b1);

        // Reset during WB of OUT clears the strobe immediately
        issue(3'd5, 2'd1, 2'd0, 8'h77);
        issue(3'd6, 2'd1, 2'd0, 8'h00);
        @(posedge clk);
        #2;
        chk1("OUT in WB", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("async reset out_valid", out_valid, 1'b0);
        chk8("async reset out_data", out_data, 8'h00);
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(2);
        chk_reg("post-reset R1", 2'd1, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 8-bit data, 4 registers.
REQ-002 clk  in  1  single clock, rising-edge active.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 ins_valid  in  1  instruction offered; ins_ready  out  1  block can accept.
REQ-005 ins_op  in  3  opcode; ins_rd  in  2  destination/B register; ins_rs  in  2  source/A register; ins_imm  in  8  immediate.
REQ-006 alu_m  out  1, alu_s  out  4, alu_a  out  8, alu_b  out  8  controls and operands driven to the external ALU.
REQ-007 alu_t  in  8, alu_cf  in  1, alu_zf  in  1  ALU result and flags, combinational from alu_* outputs.
REQ-008 out_valid  out  1, out_data  out  8  one-cycle output strobe and data for OUT.
REQ-009 flag_c  out  1, flag_z  out  1  registered flags.
REQ-010 dbg_sel  in  2, dbg_data  out  8  combinational register-file read.

Function
REQ-011 FSM states SHALL be IDLE, EXEC, WB; IDLE->EXEC on ins_valid&&ins_ready, EXEC->WB unconditionally, WB->IDLE unconditionally.
REQ-012 ins_ready SHALL be 1 exactly in IDLE; the instruction fields SHALL be latched on the accepting edge and the inputs ignored until the next IDLE.
REQ-013 In EXEC/WB the block SHALL drive alu_a=R[rs] and alu_b=R[rd] (registers sampled at acceptance), except LDI/OUT as stated below.
REQ-014 Opcode map (m,s): 000 MOV R[rd]<=R[rs]: m=0,s=1010,b=R[rs]; 001 ADD R[rd]<=R[rd]+R[rs]: m=1,s=1001; 010 SUB R[rd]<=R[rd]-R[rs]: m=1,s=0110; 011 AND: m=1,s=1011; 100 NOT R[rd]<=~R[rs]: m=1,s=0101,b=R[rs].
REQ-015 101 LDI R[rd]<=imm: m=0,s=1100,a=imm; 110 OUT: m=0,s=1100,a=R[rd], no register write; 111 NOP: m=0,s=0000, no write.
REQ-016 In IDLE the block SHALL drive alu_m=0, alu_s=0000, alu_a=0, alu_b=0.
REQ-017 At the WB->IDLE edge the block SHALL write alu_t to R[rd] for opcodes 000-101; latency: accept edge N, register visible after edge N+2, next acceptance at edge N+3 earliest.
REQ-018 At the same edge flag_c<=alu_cf and flag_z<=alu_zf for ADD, SUB; flag_c<=0, flag_z<=(alu_t==0) for AND, NOT; flags unchanged for MOV, LDI, OUT, NOP.
REQ-019 For OUT, out_valid SHALL be 1 during WB only, with out_data=alu_t; otherwise out_valid=0 and out_data holds its last value.
REQ-020 ADD/SUB SHALL wrap modulo 256; carry/borrow is taken solely from alu_cf.
REQ-021 rd==rs SHALL be legal (e.g. SUB r1,r1 yields 0, flag_z=1).
REQ-022 ins_valid held high continuously SHALL be accepted once per 3 cycles, never twice per instruction.
REQ-023 dbg_data SHALL equal R[dbg_sel] from register state, independent of FSM state.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, R0-R3=0, flag_c=0, flag_z=0, out_valid=0, out_data=0; ins_ready=1 once rst_n is high.
REQ-025 Reset asserted in EXEC or WB SHALL abort the instruction with no register, flag or out_valid effect.

Verification (bench uses a behavioural ALU with zf=(t==0))
REQ-026 LDI r0,0x05; LDI r1,0x03; ADD r0,r1 -> R0=0x08, flag_c=0, flag_z=0, each write exactly 2 cycles after acceptance.
REQ-027 LDI r2,0xFF; LDI r3,0x01; ADD r2,r3 -> R2=0x00, flag_c=1, flag_z=1.
REQ-028 LDI r0,0x03; LDI r1,0x05; SUB r0,r1 -> R0=0xFE, flag_c=1; then NOT r2,r0 -> R2=0x01, flag_c=0, flag_z=0.
REQ-029 LDI r1,0xA5; OUT r1 -> single-cycle out_valid with out_data=0xA5; R1 and flags unchanged.
REQ-030 ins_valid held high with back-to-back LDIs -> ins_ready pulses every 3rd cycle, each instruction applied once.
REQ-031 Reset pulsed during EXEC of ADD r0,r1 (R0=0x08) -> all registers 0x00, flags 0, no out_valid, ins_ready=1 after release.
